mem_lsu: RTL and testbench

- Load/store unit between the M stage and the data memory of the pipelined CPU.
- Store path: narrows 32-bit register data to byte, halfword or word lanes, producing byte enables and lane-replicated write data.
- Load path: sign- or zero-extends the selected lane back to 32 bits.
- Checks alignment, runs a req/ack handshake with the data memory, and returns one registered response per accepted request.

---
 rtl/mem_pkg.sv | 60 ++++++
 rtl/mem_lsu_if.sv | 36 +++
 rtl/lsu_load_ext.sv | 29 ++
 rtl/mem_lsu.sv | 106 ++++++++++
 tb/tb_mem_lsu.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: op and exception encodings, FSM states
// and the lane helpers used on the store path.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_ADEL = 2'b01,
    EXC_ADES = 2'b10
  } exc_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  function automatic logic is_store(input logic [2:0] op);
    case (op)
      OP_SW, OP_SH, OP_SB: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // Anything that is not a byte or halfword op is handled as a word op.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1'b0;
      OP_LH, OP_LHU, OP_SH: return lane[0];
      default:              return (lane != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      OP_SB:   return 4'b0001 << lane;
      OP_SH:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wd);
    case (op)
      OP_SB:   return {4{wd[7:0]}};
      OP_SH:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// M-stage request/response and data-memory bus of the load/store unit.
// slave is the unit itself; master is the CPU plus memory environment around it.
interface mem_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              flush;
  logic              dm_en;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_be;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_exc;
  logic              busy;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, flush, dm_rdata, dm_ack,
    output req_ready, dm_en, dm_we, dm_addr, dm_be, dm_wdata,
           rsp_valid, rsp_rdata, rsp_exc, busy
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, flush, dm_rdata, dm_ack,
    input  req_ready, dm_en, dm_we, dm_addr, dm_be, dm_wdata,
           rsp_valid, rsp_rdata, rsp_exc, busy
  );
endinterface

// File: rtl/lsu_load_ext.sv
// Load-path lane select and sign/zero extension of a memory word.
module lsu_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  op,
  output logic [31:0] data
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = addr[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  data = {24'd0, lane_b};
      OP_LH:   data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  data = {16'd0, lane_h};
      default: data = word;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: registers one M-stage op, checks alignment, runs the data-memory
// req/ack handshake and returns a single registered response.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  mem_lsu_if.slave bus
);
  state_e            state_q, state_d;
  logic              accept;
  logic              ack_hit;
  logic              misal;
  logic [2:0]        op_p1;
  logic [1:0]        lane_p1;
  logic              kill_p1;
  logic              rsp_vld_p2;
  logic [DATA_W-1:0] ext_data;

  assign misal = misaligned(bus.req_op, bus.req_addr[1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ack_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          accept  = 1'b1;
          state_d = misal ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (bus.dm_ack) begin
          ack_hit = 1'b1;
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  lsu_load_ext u_ext (
    .word (bus.dm_rdata),
    .addr (lane_p1),
    .op   (op_p1),
    .data (ext_data)
  );

  // p1: request captured at accept; memory-side outputs driven from these registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.dm_en    <= 1'b0;
      bus.dm_we    <= 1'b0;
      bus.dm_be    <= 4'b0000;
      bus.dm_addr  <= '0;
      bus.dm_wdata <= '0;
      op_p1        <= 3'b000;
      lane_p1      <= 2'b00;
      kill_p1      <= 1'b0;
      rsp_vld_p2   <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_exc  <= EXC_NONE;
    end else begin
      rsp_vld_p2 <= 1'b0;
      if (accept) begin
        op_p1   <= bus.req_op;
        lane_p1 <= bus.req_addr[1:0];
        if (misal) begin
          rsp_vld_p2    <= 1'b1;
          bus.rsp_rdata <= '0;
          bus.rsp_exc   <= is_store(bus.req_op) ? EXC_ADES : EXC_ADEL;
        end else begin
          bus.dm_en    <= 1'b1;
          bus.dm_we    <= is_store(bus.req_op);
          bus.dm_be    <= byte_en(bus.req_op, bus.req_addr[1:0]);
          bus.dm_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
          bus.dm_wdata <= store_data(bus.req_op, bus.req_wdata);
          bus.rsp_exc  <= EXC_NONE;
        end
      end
      // A flushed access still runs to its ack so a store is never torn.
      if (bus.flush && state_q != ST_IDLE) kill_p1 <= 1'b1;
      // p2: ack closes the access and registers the response
      if (ack_hit) begin
        bus.dm_en     <= 1'b0;
        bus.dm_we     <= 1'b0;
        rsp_vld_p2    <= !kill_p1 && !bus.flush;
        bus.rsp_rdata <= is_store(op_p1) ? '0 : ext_data;
      end
      if (state_q == ST_RESP) kill_p1 <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_vld_p2 && !bus.flush;
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_lsu.sv
// Randomised scoreboard bench for mem_lsu against a byte-addressed memory reference model.
module tb_mem_lsu;
  import mem_pkg::*;

  typedef struct { logic [31:0] rdata; logic [1:0] exc; } rsp_t;
  typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } acc_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ack_delay = 0;
  bit   spurious = 1'b0;

  rsp_t rsp_q[$];
  acc_t acc_q[$];
  logic [7:0]  ref_mem [256];
  logic [31:0] phys    [64];

  mem_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic int sz_of(input logic [2:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LB, OP_LBU, OP_SB: return 1;
      default:              return 4;
    endcase
  endfunction

  function automatic bit is_st(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    longint unsigned v = 0;
    int sz = sz_of(op);
    for (int k = 0; k < sz; k++) v |= longint'(ref_mem[8'(a + k)]) << (8 * k);
    if (sz < 4 && (op == OP_LB || op == OP_LH) && v[8 * sz - 1])
      v |= ~((64'd1 << (8 * sz)) - 1);
    return v[31:0];
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    phys[a[7:2]] = w;
    for (int k = 0; k < 4; k++) ref_mem[{a[7:2], 2'b00} + 8'(k)] = w[8 * k +: 8];
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Applies the reference rules, issues the op and checks latency / return to idle.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input bit fl, input int dly);
    int   sz  = sz_of(op);
    bit   mis = (a % sz) != 0;
    int   lat;
    acc_t x;
    rsp_t r;
    ack_delay = dly;
    if (!mis) begin
      x.we    = is_st(op);
      x.be    = is_st(op) ? 4'(((1 << sz) - 1) << a[1:0]) : 4'hF;
      x.addr  = a & ~32'd3;
      for (int k = 0; k < 4; k++) x.wdata[8 * k +: 8] = wd[8 * (k % sz) +: 8];
      acc_q.push_back(x);
    end
    r.exc   = mis ? (is_st(op) ? 2'b10 : 2'b01) : 2'b00;
    r.rdata = (mis || is_st(op)) ? 32'd0 : ref_load(op, a);
    if (!mis && is_st(op))
      for (int k = 0; k < sz; k++) ref_mem[8'(a + k)] = wd[8 * k +: 8];
    if (!fl) rsp_q.push_back(r);
    issue(op, a, wd);
    if (fl) begin
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      lat = 0;
      while (bus.busy && lat < 40) begin @(posedge clk); #1; lat++; end
    end else begin
      lat = 1;
      while (!bus.rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      check("latency", lat, mis ? 1 : dly + 2);
      @(posedge clk); #1;
    end
    check("idle_after_op", {bus.busy, bus.req_ready}, 2'b01);
    check("access_done", acc_q.size(), 0);
  endtask

  // Memory: acks after ack_delay dm_en cycles and checks every presented access.
  initial begin
    bus.dm_ack   = 1'b0;
    bus.dm_rdata = '0;
    forever begin
      int cnt = 0;
      @(posedge clk); #1;
      bus.dm_ack   = 1'b0;
      bus.dm_rdata = $urandom;
      if (!bus.dm_en || !reset_n) begin
        cnt = 0;
        bus.dm_ack = spurious && reset_n;
      end else if (acc_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dm_en_unexpected addr=0x%08h required no access", bus.dm_addr);
      end else begin
        check("dm_addr", bus.dm_addr, acc_q[0].addr);
        check("dm_we", bus.dm_we, acc_q[0].we);
        check("dm_be", bus.dm_be, acc_q[0].be);
        if (acc_q[0].we) check("dm_wdata", bus.dm_wdata, acc_q[0].wdata);
        if (cnt >= ack_delay) begin
          bus.dm_ack   = 1'b1;
          bus.dm_rdata = phys[bus.dm_addr[7:2]];
          if (bus.dm_we)
            for (int k = 0; k < 4; k++)
              if (bus.dm_be[k]) phys[bus.dm_addr[7:2]][8 * k +: 8] = bus.dm_wdata[8 * k +: 8];
          void'(acc_q.pop_front());
          cnt = 0;
        end else cnt++;
      end
    end
  end

  rsp_t m;
  always @(negedge clk) begin
    if (reset_n && bus.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected rdata=0x%08h exc=%0d required no response",
                 bus.rsp_rdata, bus.rsp_exc);
      end else begin
        m = rsp_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, m.rdata);
        check("rsp_exc", {30'd0, bus.rsp_exc}, {30'd0, m.exc});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.flush     = 1'b0;
    for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_busy", {bus.req_ready, bus.busy}, 2'b10);
    check("rst_dm_ctrl", {bus.dm_en, bus.dm_we, bus.dm_be}, 6'd0);
    check("rst_dm_addr", bus.dm_addr, 0);
    check("rst_dm_wdata", bus.dm_wdata, 0);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_exc}, 3'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);

    do_op(OP_SB, 32'h1003, 32'h000000A5, 1'b0, 2);
    preload(32'h2000, 32'h12F03456);
    do_op(OP_LB, 32'h2002, 32'h0, 1'b0, 0);
    do_op(OP_LBU, 32'h2002, 32'h0, 1'b0, 1);
    preload(32'h2000, 32'h8001FFFF);
    do_op(OP_LH, 32'h2002, 32'h0, 1'b0, 0);
    do_op(OP_LHU, 32'h2002, 32'h0, 1'b0, 3);
    do_op(OP_LW, 32'h3001, 32'h0, 1'b0, 0);
    do_op(OP_SH, 32'h3003, 32'h1234, 1'b0, 0);
    do_op(OP_SW, 32'h0010, 32'hDEADBEEF, 1'b1, 2);
    do_op(OP_LW, 32'h0010, 32'h0, 1'b0, 0);

    // flush while idle blocks acceptance
    bus.req_valid = 1'b1; bus.flush = 1'b1;
    bus.req_op = OP_SW; bus.req_addr = 32'h80; bus.req_wdata = 32'h55;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    check("flush_idle_block", bus.busy, 0);

    // ack outside ACCESS must be ignored
    spurious = 1'b1;
    repeat (3) @(posedge clk);
    #1 spurious = 1'b0;
    check("spurious_ack_idle", bus.busy, 0);

    // reset during an access
    ack_delay = 10;
    acc_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h40, wdata: 32'h0});
    issue(OP_LW, 32'h40, 32'h0);
    @(posedge clk); #1;
    check("dm_en_pre_reset", bus.dm_en, 1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_async_dm_en", bus.dm_en, 0);
    check("reset_async_busy", bus.busy, 0);
    acc_q.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    do_op(OP_LW, 32'h0, 32'h0, 1'b0, 0);

    for (int i = 0; i < 250; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = {24'd0, 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz_of(op) - 1);
      do_op(op, a, $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    check("rsp_queue_empty", rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
